// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI stash slice.
package spi_pkg;

  localparam int SPI_BYTE_W    = 8;
  localparam int DEFAULT_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/spi_stash_if.sv
// Host-side bus of the SPI stash: TX writes, RX reads and the start/done handshake.
interface spi_stash_if #(
  parameter int AW = 4
);
  import spi_pkg::*;

  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [SPI_BYTE_W-1:0] wr_data;
  logic [AW-1:0]         rd_addr;
  logic [SPI_BYTE_W-1:0] rd_data;
  logic                  start;
  logic [AW:0]           len;
  logic                  busy;
  logic                  done;

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, start, len,
    output rd_data, busy, done
  );

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, start, len,
    input  rd_data, busy, done
  );

endinterface

// File: rtl/spi_stash_ram.sv
// Byte RAM with one write port and one registered, enable-gated read port.
module spi_stash_ram
  import spi_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = 4
) (
  input  logic                  CTRL_CLK,
  input  logic                  NRST,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [SPI_BYTE_W-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [SPI_BYTE_W-1:0] rdata
);

  logic [SPI_BYTE_W-1:0] mem [DEPTH];

  // Storage is deliberately left out of reset.
  always_ff @(posedge CTRL_CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read-before-write: a same-slot write shows up on the following read.
  always_ff @(posedge CTRL_CLK) begin
    if (!NRST)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/spi_stash.sv
// Byte stash between host and SPI master: TX bytes fed by the master's pointer,
// RX bytes captured on each pointer change, transfer gated by active-low ENABLE.
module spi_stash
  import spi_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                  CTRL_CLK,
  input  logic                  NRST,
  spi_stash_if.slave            host,
  output logic                  ENABLE,
  output logic [SPI_BYTE_W-1:0] MOSI_data,
  input  logic [7:0]            stash_ptr,
  input  logic [SPI_BYTE_W-1:0] MISO_data
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  state_t                state;
  logic [7:0]            base;
  logic [7:0]            ptr_q;
  logic [AW:0]           count;
  logic [AW:0]           count_nx;
  logic [AW:0]           len_q;
  logic [AW:0]           len_sat;
  logic                  busy_q;
  logic                  done_q;
  logic                  ptr_event;
  logic                  tx_re;
  logic [AW-1:0]         tx_raddr;
  logic                  rx_we;
  logic [AW-1:0]         rx_waddr;
  logic [SPI_BYTE_W-1:0] rx_rdata;

  assign count_nx  = count + (AW+1)'(1);
  assign len_sat   = (host.len > DEPTH_L) ? DEPTH_L : host.len;
  assign ptr_event = (stash_ptr != ptr_q);

  // 8-bit offset truncated to AW bits keeps a 255->0 pointer wrap transparent.
  assign tx_re    = (state == ARM) || (state == RUN);
  assign tx_raddr = (state == ARM) ? '0 : AW'(stash_ptr - base);
  assign rx_we    = NRST && (state == RUN) && ptr_event;
  assign rx_waddr = AW'(ptr_q - base);

  assign host.busy    = busy_q;
  assign host.done    = done_q;
  assign host.rd_data = rx_rdata;

  always_ff @(posedge CTRL_CLK) begin
    if (!NRST) begin
      state  <= IDLE;
      base   <= '0;
      ptr_q  <= '0;
      count  <= '0;
      len_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ENABLE <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (host.start) begin
            busy_q <= 1'b1;
            if (host.len != '0) begin
              len_q <= len_sat;
              base  <= stash_ptr;
              ptr_q <= stash_ptr;
              count <= '0;
              state <= ARM;
            end else begin
              done_q <= 1'b1;
              state  <= DONE;
            end
          end
        end
        ARM: begin
          ENABLE <= 1'b0;
          state  <= RUN;
        end
        RUN: begin
          if (ptr_event) begin
            ptr_q <= stash_ptr;
            count <= count_nx;
            if (count_nx == len_q) begin
              ENABLE <= 1'b1;
              done_q <= 1'b1;
              state  <= DONE;
            end
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  spi_stash_ram #(.DEPTH(DEPTH), .AW(AW)) u_tx_ram (
    .CTRL_CLK (CTRL_CLK),
    .NRST     (NRST),
    .we       (host.wr_en),
    .waddr    (host.wr_addr),
    .wdata    (host.wr_data),
    .re       (tx_re),
    .raddr    (tx_raddr),
    .rdata    (MOSI_data)
  );

  spi_stash_ram #(.DEPTH(DEPTH), .AW(AW)) u_rx_ram (
    .CTRL_CLK (CTRL_CLK),
    .NRST     (NRST),
    .we       (rx_we),
    .waddr    (rx_waddr),
    .wdata    (MISO_data),
    .re       (1'b1),
    .raddr    (host.rd_addr),
    .rdata    (rx_rdata)
  );

endmodule

// File: doc/spi_stash.md
Name: spi_stash

Overview:
- Byte-buffer stage between the host/control logic and the SPI master.
- Holds a TX stash that the master reads byte-by-byte through the master's stash pointer.
- Captures each received byte into an RX stash, and gates the master's transaction with an active-low enable.
- A host writes TX bytes, issues start with a length, waits for done, then reads the RX bytes.

Parameters:
DEPTH, 16, number of byte slots in each stash (power of 2, 2..128)
AW, 4, address width, equal to log2(DEPTH)

Ports:
CTRL_CLK  in  1  system clock; all logic on posedge
NRST  in  1  synchronous, active-low reset
wr_en  in  1  host write strobe into TX stash
wr_addr  in  AW  TX slot index
wr_data  in  8  TX byte
rd_addr  in  AW  RX slot index
rd_data  out  8  RX byte at rd_addr, registered, 1-cycle latency
start  in  1  single-cycle request to run a transfer
len  in  AW+1  byte count, sampled on accepted start (0..DEPTH)
busy  out  1  high from accepted start until done
done  out  1  single-cycle pulse when the last byte is captured
ENABLE  out  1  active-low transfer enable to the SPI master
MOSI_data  out  8  TX byte for the master's current pointer, registered
stash_ptr  in  8  master byte pointer; increments once per completed byte and wraps mod 256
MISO_data  in  8  master received byte; valid in the cycle stash_ptr changes

Behaviour:
- Reset values (NRST low at posedge):
  - ENABLE=1, busy=0, done=0, MOSI_data=0, rd_data=0.
  - FSM in IDLE; base, count and ptr_q cleared.
  - Stash contents are not reset.
- FSM states: IDLE, ARM, RUN, DONE.
- IDLE:
  - start=1 with len!=0: latch len, base<=stash_ptr, ptr_q<=stash_ptr, count<=0, busy<=1, go to ARM.
  - start=1 with len==0: go to DONE directly; ENABLE stays 1.
- ARM: preload MOSI_data <= tx[0]; ENABLE<=0; go to RUN. ENABLE therefore falls 2 cycles after start.
- RUN:
  - Byte-completion event: stash_ptr != ptr_q.
  - On each event: rx[(ptr_q-base) mod DEPTH] <= MISO_data; count<=count+1; ptr_q<=stash_ptr.
  - Every cycle: MOSI_data <= tx[(stash_ptr-base) mod DEPTH], 8-bit subtraction truncated to AW bits, so pointer wrap 255->0 is transparent.
  - When an event makes count+1==len: ENABLE<=1, go to DONE.
- DONE: done=1 for exactly one cycle, busy<=0, return to IDLE.
- Only a change of stash_ptr is an event, never its value. A pointer jump of more than 1 in one cycle still counts as one byte.
- start while busy=1 is ignored.
- Host writes:
  - Accepted in any state.
  - A write during RUN to the slot currently addressed updates MOSI_data next cycle. The result is undefined on the wire if the master already loaded the byte; the bench must not rely on it.
- Reads: rd_data <= rx[rd_addr] every cycle, in any state.
- Simultaneous RX capture and host read of the same slot: rd_data returns the old value, new value on the next cycle.
- Reset mid-RUN: ENABLE returns high on the next edge; the transfer is aborted with no done pulse; RX contents captured so far are retained.
- len > DEPTH is treated as DEPTH (saturate on sampling).

Decomposition:
- Shared package spi_pkg:
  - FSM state encoding (IDLE, ARM, RUN, DONE).
  - SPI_BYTE_W=8.
  - Default DEPTH.
- Sub-module spi_stash_ram: single clock, one write port and one registered read port, 8-bit, DEPTH deep.
  - Instantiated twice: TX (host write, master read) and RX (master write, host read).

Test Plan:
- Reset then idle: NRST low 2 cycles -> ENABLE=1, busy=0, done=0, MOSI_data=0; start with len=0 -> done pulse 1 cycle later, ENABLE never low.
- Basic 3-byte run: write tx[0..2]=A5,3C,F0; stash_ptr=10; start len=3 -> ENABLE low 2 cycles later, MOSI_data=A5. Bump ptr to 11/12/13 with MISO_data=11,22,33 -> MOSI_data follows 3C,F0. After the third bump: ENABLE=1, done pulse; rd_addr 0..2 returns 11,22,33.
- Pointer wrap: stash_ptr=254 at start, len=4; pointer steps 255,0,1,2 -> rx[0..3] filled in order; MOSI_data indexes tx[1..3] correctly across the wrap.
- Start while busy: second start mid-RUN with len=1 -> ignored; completion still after the original len bytes with a single done pulse.
- Reset mid-transfer: NRST low after 1 of 4 bytes -> ENABLE=1 next edge, no done pulse, rx[0] retains the captured byte.
- Full depth: len=DEPTH (16) with a full TX pattern 00..0F and MISO echo -> rx equals tx; done after exactly 16 pointer events.
